// File: rtl/cpu_mem_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// req/we/addr/be/wdata come from the MEM stage; ack/rdata come back from memory.
interface cpu_mem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/cpu_mem.sv
// MEM pipeline stage: issues loads/stores on the data-memory bus with a req/ack handshake,
// stalls the front end while an access is outstanding and drives the MEM/WB latch.
module cpu_mem #(
  parameter int              TIMEOUT_CYCLES = 255,
  parameter int              CON_W          = 8,
  parameter int              CON_MEM_READ   = 0,
  parameter int              CON_MEM_WRITE  = 1,
  parameter int              CON_MEM_SIZE   = 2,
  parameter int              CON_MEM_SIGN   = 4,
  parameter logic [CON_W-1:0] CON_NOP       = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      current_pc_ex,
  input  logic [31:0]      ins_ex,
  input  logic [CON_W-1:0] controls_ex,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      reg_read2_data_ex,
  output logic             stall,
  cpu_mem_if.master        dmem,
  output logic [31:0]      current_pc_mem,
  output logic [31:0]      ins_mem,
  output logic [CON_W-1:0] controls_mem,
  output logic [31:0]      alu_result_mem,
  output logic [31:0]      mem_data_mem,
  output logic             addr_error,
  output logic             bus_error
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic             req_nxt, we_nxt;
  logic [31:0]      addr_nxt, wdata_nxt;
  logic [3:0]       be_nxt;
  logic [31:0]      pc_nxt, ins_nxt, alu_nxt, mdata_nxt;
  logic [CON_W-1:0] con_nxt;
  logic             aerr_nxt, berr_nxt;

  logic             mem_rd, mem_wr, mem_op, mem_sgn, misaligned;
  logic [1:0]       mem_size, a_lo;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   lane_be = 4'b0001 << a;
      2'b01:   lane_be = a[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   lane_wdata = {4{d[7:0]}};
      2'b01:   lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

  // Pick the addressed byte/half out of the little-endian word, then sign- or zero-extend.
  function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] a,
                                              input logic [1:0] size, input logic sgn);
    logic [31:0]        shifted;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    shifted = rdata >> {a, 3'b000};
    b = shifted[7:0];
    h = shifted[15:0];
    case (size)
      2'b00:   load_extend = sgn ? 32'(b) : 32'(shifted[7:0]);
      2'b01:   load_extend = sgn ? 32'(h) : 32'(shifted[15:0]);
      default: load_extend = rdata;
    endcase
  endfunction

  assign mem_rd     = controls_ex[CON_MEM_READ];
  assign mem_wr     = controls_ex[CON_MEM_WRITE];
  assign mem_op     = mem_rd | mem_wr;
  assign mem_sgn    = controls_ex[CON_MEM_SIGN];
  assign mem_size   = controls_ex[CON_MEM_SIZE +: 2];
  assign a_lo       = alu_result[1:0];
  assign misaligned = ((mem_size == 2'b01) && a_lo[0]) || (mem_size[1] && (a_lo != 2'b00));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_nxt   = dmem.req;
    we_nxt    = dmem.we;
    addr_nxt  = dmem.addr;
    be_nxt    = dmem.be;
    wdata_nxt = dmem.wdata;
    pc_nxt    = current_pc_mem;
    ins_nxt   = ins_mem;
    alu_nxt   = alu_result_mem;
    con_nxt   = controls_mem;
    mdata_nxt = mem_data_mem;
    aerr_nxt  = 1'b0;
    berr_nxt  = 1'b0;
    stall     = 1'b0;

    unique case (state)
      IDLE: begin
        if (!mem_op) begin
          pc_nxt    = current_pc_ex;
          ins_nxt   = ins_ex;
          alu_nxt   = alu_result;
          con_nxt   = controls_ex;
          mdata_nxt = '0;
        end else if (misaligned) begin
          pc_nxt    = current_pc_ex;
          ins_nxt   = ins_ex;
          alu_nxt   = alu_result;
          con_nxt   = CON_NOP;
          mdata_nxt = '0;
          aerr_nxt  = 1'b1;
        end else begin
          stall     = 1'b1;
          req_nxt   = 1'b1;
          we_nxt    = mem_wr;
          addr_nxt  = {alu_result[31:2], 2'b00};
          be_nxt    = lane_be(mem_size, a_lo);
          wdata_nxt = lane_wdata(mem_size, reg_read2_data_ex);
          cnt_nxt   = '0;
          con_nxt   = CON_NOP;
          mdata_nxt = '0;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        // The EX latch is frozen by stall, so its fields still describe the access in flight.
        if (dmem.ack) begin
          pc_nxt    = current_pc_ex;
          ins_nxt   = ins_ex;
          alu_nxt   = alu_result;
          con_nxt   = controls_ex;
          mdata_nxt = mem_rd ? load_extend(dmem.rdata, a_lo, mem_size, mem_sgn) : '0;
          req_nxt   = 1'b0;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          pc_nxt    = current_pc_ex;
          ins_nxt   = ins_ex;
          alu_nxt   = alu_result;
          con_nxt   = CON_NOP;
          mdata_nxt = '0;
          req_nxt   = 1'b0;
          berr_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall     = 1'b1;
          cnt_nxt   = cnt + CNT_W'(1);
          con_nxt   = CON_NOP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus request and MEM/WB latch register stage
  always_ff @(posedge clk) begin
    if (!clr) begin
      state          <= IDLE;
      cnt            <= '0;
      dmem.req       <= 1'b0;
      dmem.we        <= 1'b0;
      dmem.addr      <= '0;
      dmem.be        <= '0;
      dmem.wdata     <= '0;
      current_pc_mem <= '0;
      ins_mem        <= '0;
      alu_result_mem <= '0;
      controls_mem   <= CON_NOP;
      mem_data_mem   <= '0;
      addr_error     <= 1'b0;
      bus_error      <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      dmem.req       <= req_nxt;
      dmem.we        <= we_nxt;
      dmem.addr      <= addr_nxt;
      dmem.be        <= be_nxt;
      dmem.wdata     <= wdata_nxt;
      current_pc_mem <= pc_nxt;
      ins_mem        <= ins_nxt;
      alu_result_mem <= alu_nxt;
      controls_mem   <= con_nxt;
      mem_data_mem   <= mdata_nxt;
      addr_error     <= aerr_nxt;
      bus_error      <= berr_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_mem.sv
// Self-checking bench for cpu_mem: directed vector table, hand-written corner sequences,
// and randomized transactions checked against a byte-lane arithmetic reference model.
module tb_cpu_mem;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] current_pc_ex, ins_ex, alu_result, reg_read2_data_ex;
  logic [7:0]  controls_ex;
  logic        stall;
  logic [31:0] current_pc_mem, ins_mem, alu_result_mem, mem_data_mem;
  logic [7:0]  controls_mem;
  logic        addr_error, bus_error;

  int n_cmp  = 0;
  int n_fail = 0;

  cpu_mem_if bus ();

  cpu_mem #(.TIMEOUT_CYCLES(T)) dut (
    .clk               (clk),
    .clr               (clr),
    .current_pc_ex     (current_pc_ex),
    .ins_ex            (ins_ex),
    .controls_ex       (controls_ex),
    .alu_result        (alu_result),
    .reg_read2_data_ex (reg_read2_data_ex),
    .stall             (stall),
    .dmem              (bus),
    .current_pc_mem    (current_pc_mem),
    .ins_mem           (ins_mem),
    .controls_mem      (controls_mem),
    .alu_result_mem    (alu_result_mem),
    .mem_data_mem      (mem_data_mem),
    .addr_error        (addr_error),
    .bus_error         (bus_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Control bus encoding: bit0 read, bit1 write, bits3:2 size, bit4 sign, bit7 marks a reg-writing op.
  function automatic logic [7:0] mk_con(input logic rd, input logic wr, input logic [1:0] sz,
                                        input logic sg);
    return {3'b100, sg, sz, wr, rd};
  endfunction

  // kind: 0 non-mem, 1 misaligned, 2 acked after `delay` waiting cycles, 3 timeout
  task automatic drive_op(input string nm, input logic [7:0] con, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] rdata, input int delay,
                          input int kind, input logic [3:0] be, input logic [31:0] wdata,
                          input logic [31:0] mdata, input logic [31:0] pc);
    bit acked;
    current_pc_ex     = pc;
    ins_ex            = pc ^ 32'h0badf00d;
    controls_ex       = con;
    alu_result        = addr;
    reg_read2_data_ex = data;
    bus.ack           = 1'b0;
    bus.rdata         = 32'h0;
    @(negedge clk);
    chk({nm, ".stall_idle"}, 32'(stall), 32'(kind >= 2));
    @(posedge clk); #1;
    if (kind == 0) begin
      chk({nm, ".ctl"}, 32'(controls_mem), 32'(con));
      chk({nm, ".alu"}, alu_result_mem, addr);
      chk({nm, ".pc"}, current_pc_mem, pc);
      chk({nm, ".ins"}, ins_mem, pc ^ 32'h0badf00d);
      chk({nm, ".mdata"}, mem_data_mem, 32'h0);
      chk({nm, ".errs"}, 32'({addr_error, bus_error}), 32'h0);
    end else if (kind == 1) begin
      chk({nm, ".req"}, 32'(bus.req), 32'h0);
      chk({nm, ".aerr"}, 32'(addr_error), 32'h1);
      chk({nm, ".ctl"}, 32'(controls_mem), 32'h0);
      chk({nm, ".alu"}, alu_result_mem, addr);
    end else begin
      chk({nm, ".req"}, 32'(bus.req), 32'h1);
      chk({nm, ".we"}, 32'(bus.we), 32'(con[1]));
      chk({nm, ".addr"}, bus.addr, {addr[31:2], 2'b00});
      chk({nm, ".be"}, 32'(bus.be), 32'(be));
      if (con[1]) chk({nm, ".wdata"}, bus.wdata, wdata);
      chk({nm, ".bubble"}, 32'(controls_mem), 32'h0);
      chk({nm, ".errs0"}, 32'({addr_error, bus_error}), 32'h0);
      acked = 0;
      for (int w = 0; w < T && !acked; w++) begin
        if (kind == 2 && w == delay) begin
          bus.ack   = 1'b1;
          bus.rdata = rdata;
          acked     = 1;
        end
        @(negedge clk);
        chk({nm, ".req_held"}, 32'(bus.req), 32'h1);
        chk({nm, ".stall_acc"}, 32'(stall), 32'(!(acked || w == T - 1)));
        @(posedge clk); #1;
        bus.ack = 1'b0;
        if (!acked && w < T - 1) chk({nm, ".wait_bubble"}, 32'(controls_mem), 32'h0);
      end
      chk({nm, ".req_done"}, 32'(bus.req), 32'h0);
      if (kind == 2) begin
        chk({nm, ".ctl"}, 32'(controls_mem), 32'(con));
        chk({nm, ".mdata"}, mem_data_mem, mdata);
        chk({nm, ".pc"}, current_pc_mem, pc);
        chk({nm, ".berr"}, 32'(bus_error), 32'h0);
      end else begin
        chk({nm, ".berr"}, 32'(bus_error), 32'h1);
        chk({nm, ".ctl_to"}, 32'(controls_mem), 32'h0);
      end
    end
  endtask

  typedef struct {
    string       nm;
    logic [7:0]  con;
    logic [31:0] addr, data, rdata;
    int          delay, kind;
    logic [3:0]  be;
    logic [31:0] wdata, mdata;
  } vec_t;

  vec_t vecs[11];

  // Reference model: transaction outcome from size/offset arithmetic.
  task automatic model(input logic [7:0] con, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] rdata, input int delay, output int kind,
                       output logic [3:0] be, output logic [31:0] wdata, output logic [31:0] mdata);
    int     nb, off;
    longint v;
    nb    = (con[3:2] == 2'd0) ? 1 : (con[3:2] == 2'd1) ? 2 : 4;
    off   = int'(addr % 32'd4);
    be    = 4'(((1 << nb) - 1) << off);
    wdata = '0;
    for (int l = 0; l < 4; l++) wdata[8*l +: 8] = data[8*(l % nb) +: 8];
    mdata = '0;
    if (con[0]) begin
      v = (longint'(rdata) >> (8 * off)) & ((longint'(1) << (8 * nb)) - 1);
      if (con[4] && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
      mdata = 32'(v);
    end
    if (!(con[0] || con[1])) kind = 0;
    else if ((off % nb) != 0) kind = 1;
    else if (delay >= T) kind = 3;
    else kind = 2;
  endtask

  initial begin
    int          kind;
    logic [3:0]  be;
    logic [31:0] wd, md, addr;
    logic [7:0]  con;
    vecs[0]  = '{"add",    8'h80,              32'h12345678, 32'h0,        32'h0,        0, 0, 4'h0, 32'h0,        32'h0};
    vecs[1]  = '{"sw",     mk_con(0,1,2,0),    32'h100,      32'hDEADBEEF, 32'h0,        0, 2, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{"lb",     mk_con(1,0,0,1),    32'h203,      32'h0,        32'h80112233, 0, 2, 4'h8, 32'h0,        32'hFFFFFF80};
    vecs[3]  = '{"lbu",    mk_con(1,0,0,0),    32'h203,      32'h0,        32'h80112233, 0, 2, 4'h8, 32'h0,        32'h00000080};
    vecs[4]  = '{"sh",     mk_con(0,1,1,0),    32'h42,       32'h1234ABCD, 32'h0,        0, 2, 4'hC, 32'hABCDABCD, 32'h0};
    vecs[5]  = '{"lh_mis", mk_con(1,0,1,1),    32'h41,       32'h0,        32'h0,        0, 1, 4'h0, 32'h0,        32'h0};
    vecs[6]  = '{"lh",     mk_con(1,0,1,1),    32'h202,      32'h0,        32'h80112233, 2, 2, 4'hC, 32'h0,        32'hFFFF8011};
    vecs[7]  = '{"lhu",    mk_con(1,0,1,0),    32'h200,      32'h0,        32'h80112233, 1, 2, 4'h3, 32'h0,        32'h00002233};
    vecs[8]  = '{"sb",     mk_con(0,1,0,0),    32'h101,      32'h000000A5, 32'h0,        3, 2, 4'h2, 32'hA5A5A5A5, 32'h0};
    vecs[9]  = '{"lw_mis", mk_con(1,0,2,0),    32'h102,      32'h0,        32'h0,        0, 1, 4'h0, 32'h0,        32'h0};
    vecs[10] = '{"lw",     mk_con(1,0,3,0),    32'h204,      32'h0,        32'hCAFEF00D, 0, 2, 4'hF, 32'h0,        32'hCAFEF00D};

    clr = 1'b0;
    current_pc_ex = '0; ins_ex = '0; controls_ex = '0; alu_result = '0; reg_read2_data_ex = '0;
    bus.ack = 1'b0; bus.rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req", 32'(bus.req), 32'h0);
    chk("rst.bus", {bus.addr[31:4], bus.addr[3:0] | bus.be}, 32'h0);
    chk("rst.wdata", bus.wdata, 32'h0);
    chk("rst.ctl", 32'(controls_mem), 32'h0);
    chk("rst.latch", current_pc_mem | ins_mem | alu_result_mem | mem_data_mem, 32'h0);
    chk("rst.errs", 32'({addr_error, bus_error}), 32'h0);
    @(negedge clk);
    chk("rst.stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    clr = 1'b1;

    foreach (vecs[i])
      drive_op(vecs[i].nm, vecs[i].con, vecs[i].addr, vecs[i].data, vecs[i].rdata, vecs[i].delay,
               vecs[i].kind, vecs[i].be, vecs[i].wdata, vecs[i].mdata, 32'h1000 + 32'(4 * i));

    // Timeout with ack withheld, then a non-mem op shows bus_error dropped and stall free.
    drive_op("lw_to", mk_con(1,0,2,0), 32'h300, 32'h0, 32'h0, 99, 3, 4'hF, 32'h0, 32'h0, 32'h1100);
    drive_op("after_to", 8'hA0, 32'h55, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h1104);

    // Back-to-back add, lw, sw.
    drive_op("b2b_add", 8'h80, 32'h7, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h1200);
    drive_op("b2b_lw", mk_con(1,0,2,0), 32'h10, 32'h0, 32'h11223344, 0, 2, 4'hF, 32'h0, 32'h11223344, 32'h1204);
    drive_op("b2b_sw", mk_con(0,1,2,0), 32'h14, 32'h55667788, 32'h0, 0, 2, 4'hF, 32'h55667788, 32'h0, 32'h1208);

    // Reset pulsed in the second ACCESS cycle; a late ack must be ignored.
    current_pc_ex = 32'h2000; ins_ex = 32'h1; controls_ex = mk_con(1,0,2,0);
    alu_result = 32'h300; reg_read2_data_ex = 32'h0;
    @(posedge clk); #1;
    chk("rstacc.req_on", 32'(bus.req), 32'h1);
    @(posedge clk); #1;
    clr = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    current_pc_ex = '0; ins_ex = '0; controls_ex = '0; alu_result = '0;
    chk("rstacc.req_off", 32'(bus.req), 32'h0);
    chk("rstacc.bus", 32'(bus.be) | bus.addr, 32'h0);
    chk("rstacc.ctl", 32'(controls_mem), 32'h0);
    chk("rstacc.latch", current_pc_mem | alu_result_mem | mem_data_mem, 32'h0);
    bus.ack = 1'b1; bus.rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("rstacc.stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    bus.ack = 1'b0;
    chk("rstacc.mdata", mem_data_mem, 32'h0);
    chk("rstacc.req_idle", 32'(bus.req), 32'h0);
    chk("rstacc.berr", 32'(bus_error), 32'h0);

    // Randomized transactions against the reference model.
    for (int i = 0; i < 60; i++) begin
      int dly;
      logic [31:0] data, rdata;
      data  = $urandom;
      rdata = $urandom;
      dly   = $urandom_range(0, 5);
      if ($urandom_range(0, 4) == 0) begin
        con  = 8'h80 | 8'($urandom_range(0, 3) << 5);
        addr = $urandom;
      end else begin
        logic rd;
        rd   = 1'($urandom_range(0, 1));
        con  = mk_con(rd, !rd, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        addr = 32'h400 + 32'($urandom_range(0, 15));
      end
      model(con, addr, data, rdata, dly, kind, be, wd, md);
      drive_op($sformatf("rnd%0d", i), con, addr, data, rdata, dly, kind, be, wd, md,
               32'h3000 + 32'(4 * i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
